stream_source_agu: RTL and testbench

- Producer end of the valid/ready data stream consumed by the CGRA's elastic FIFOs.
- On a start pulse, generates a strided address sequence into a local scratchpad read port (1-cycle read latency).
- Emits each read word on a dout/dout_v/dout_r handshake, with a 2-entry output buffer so backpressure never drops or duplicates data.
- Sits between scratchpad memory and a PE input FIFO.

---
 rtl/stream_source_agu_if.sv | 30 +++
 rtl/stream_source_agu.sv | 128 ++++++++++++
 tb/tb_stream_source_agu.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_source_agu_if.sv
// Bundles the scratchpad read port and the outgoing valid/ready stream
// of stream_source_agu.
//   mem_en    : read strobe to scratchpad
//   mem_addr  : read address, valid while mem_en=1
//   mem_rdata : read data, valid the cycle after mem_en
//   dout      : stream data (buffer head)
//   dout_v    : stream valid
//   dout_r    : downstream ready
// master = address generator side, slave = memory/consumer side.
interface stream_source_agu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_v;
  logic                  dout_r;

  modport master (
    output mem_en, mem_addr, dout, dout_v,
    input  mem_rdata, dout_r
  );

  modport slave (
    input  mem_en, mem_addr, dout, dout_v,
    output mem_rdata, dout_r
  );
endinterface

// File: rtl/stream_source_agu.sv
// Strided scratchpad reader feeding a valid/ready stream.
// A start pulse in IDLE captures base_addr/stride/count; the unit then issues
// count reads (1-cycle latency) at base, base+stride, ... (mod 2^ADDR_WIDTH)
// and emits the words in order through a 2-entry output buffer.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   start          : launch request, only honoured in IDLE
//   base_addr      : first read address
//   stride         : two's-complement address increment
//   count          : number of words to emit
//   busy           : high from the cycle after an accepted start through DONE
//   done           : one-cycle completion pulse
//   bus            : scratchpad read port + output stream (master side)
module stream_source_agu #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH-1:0]  stride,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done,
  stream_source_agu_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [COUNT_WIDTH-1:0] issue_cnt;
  logic                   inflight;
  logic [DATA_WIDTH-1:0]  buf_mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             occ;

  logic                   pop;
  logic                   issue;
  logic [2:0]             level;

  // level = words that will occupy the buffer after this edge if no new
  // read is issued; a read is only issued when it is guaranteed a slot.
  always_comb begin
    pop   = (occ != 2'd0) && bus.dout_r;
    level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue = (state == S_RUN) && (issue_cnt != '0) && (level < 3'd2);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issue_cnt == COUNT_WIDTH'(1))) begin
          state_nxt = S_DRAIN;
        end
      end
      // Leaves as soon as the last word transfers, so DONE follows that edge.
      S_DRAIN: begin
        if (!inflight && (level == 3'd0)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    bus.mem_en   = issue;
    bus.mem_addr = addr_q;
    bus.dout     = buf_mem[rd_ptr];
    bus.dout_v   = (occ != 2'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      issue_cnt  <= '0;
      inflight   <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;

      if ((state == S_IDLE) && start) begin
        addr_q    <= base_addr;
        stride_q  <= stride;
        issue_cnt <= count;
      end else if (issue) begin
        addr_q    <= addr_q + stride_q;
        issue_cnt <= issue_cnt - COUNT_WIDTH'(1);
      end

      if (inflight) begin
        buf_mem[wr_ptr] <= bus.mem_rdata;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_stream_source_agu.sv
module tb_stream_source_agu;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 16;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;

  stream_source_agu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  stream_source_agu #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .stride   (stride),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return DW'(a) * 32'd3;
  endfunction

  // Scratchpad model: 1-cycle read latency, mem[a] = a*3.
  always @(posedge clock) begin
    if (bus.mem_en) bus.mem_rdata <= mdata(bus.mem_addr);
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] strd;
    logic [CW-1:0] cnt;
    int            mode;      // 0 ready=1, 1 ready low k=3..7, 2 random ready, 3 extra starts
    int            exp_done;  // expected done cycle relative to start (-1: unchecked)
  } job_t;

  int            nvec;
  int            nerr;
  logic [DW-1:0] q[$];
  logic          prev_v;
  logic          prev_r;
  logic [DW-1:0] prev_d;

  task automatic cmp(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, then check the stream.
  task automatic step(input logic st, input logic rdy, input logic rst);
    logic [DW-1:0] e;
    @(negedge clock);
    start      = st;
    bus.dout_r = rdy;
    reset      = rst;
    #1;
    if (prev_v && !prev_r) begin
      cmp("hold_valid", longint'(bus.dout_v), 1);
      cmp("hold_data", longint'(bus.dout), longint'(prev_d));
    end
    if (bus.dout_v && bus.dout_r) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL extra_word: got 0x%0h expected no transfer at %0t", bus.dout, $time);
      end else begin
        e = q.pop_front();
        cmp("word", longint'(bus.dout), longint'(e));
      end
    end
    prev_v = bus.dout_v && !rst;
    prev_r = rdy;
    prev_d = bus.dout;
  endtask

  task automatic run_job(input job_t j);
    logic [AW-1:0] a;
    logic [AW-1:0] aq[$];
    logic [AW-1:0] alog[$];
    int first_v, first_iss, done_at, busy_cyc, stall_iss;
    logic st, rdy;
    base_addr = j.base;
    stride    = j.strd;
    count     = j.cnt;
    a = j.base;
    for (int unsigned i = 0; i < j.cnt; i++) begin
      q.push_back(mdata(a));
      aq.push_back(a);
      a = a + j.strd;
    end
    first_v = -1; first_iss = -1; done_at = -1; busy_cyc = 0; stall_iss = 0;
    for (int k = 0; k < 300; k++) begin
      st = (k == 0) || (j.mode == 3 && (k == 2 || k == j.exp_done));
      case (j.mode)
        1:       rdy = !(k >= 3 && k <= 7);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      step(st, rdy, 1'b0);
      if (bus.mem_en) begin
        alog.push_back(bus.mem_addr);
        if (first_iss < 0) first_iss = k;
        if (j.mode == 1 && k >= 3 && k <= 7) stall_iss++;
      end
      if (bus.dout_v && first_v < 0) first_v = k;
      if (busy) busy_cyc++;
      if (done) begin
        done_at = k;
        break;
      end
    end
    cmp("done_seen", longint'(done_at >= 0), 1);
    if (j.exp_done >= 0) begin
      cmp("done_cycle", done_at, j.exp_done);
      cmp("busy_cycles", busy_cyc, j.exp_done);
    end
    if (j.cnt != 0) begin
      cmp("first_mem_en", first_iss, 1);
      cmp("first_dout_v", first_v, 3);
    end else begin
      cmp("zero_mem_en", first_iss, -1);
      cmp("zero_dout_v", first_v, -1);
    end
    if (j.mode == 1) cmp("stall_issue", stall_iss, 0);
    cmp("issue_count", alog.size(), j.cnt);
    for (int i = 0; i < alog.size() && i < aq.size(); i++) begin
      cmp("mem_addr", longint'(alog[i]), longint'(aq[i]));
    end
    cmp("words_left", q.size(), 0);
    q.delete();
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0);
      cmp("idle_busy", longint'(busy), 0);
      cmp("idle_done", longint'(done), 0);
      cmp("idle_dout_v", longint'(bus.dout_v), 0);
    end
  endtask

  job_t jobs[8];

  initial begin
    nvec = 0; nerr = 0;
    prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
    reset = 1'b1; start = 1'b0; bus.dout_r = 1'b1;
    base_addr = '0; stride = '0; count = '0;

    jobs[0] = '{base: 10'h010, strd: 10'h001, cnt: 16'd4,  mode: 0, exp_done: 7};
    jobs[1] = '{base: 10'h010, strd: 10'h001, cnt: 16'd4,  mode: 1, exp_done: 12};
    jobs[2] = '{base: 10'h001, strd: 10'h3FF, cnt: 16'd3,  mode: 0, exp_done: 6};
    jobs[3] = '{base: 10'h000, strd: 10'h000, cnt: 16'd0,  mode: 0, exp_done: 1};
    jobs[4] = '{base: 10'h100, strd: 10'h005, cnt: 16'd6,  mode: 3, exp_done: 9};
    jobs[5] = '{base: 10'h3FE, strd: 10'h000, cnt: 16'd3,  mode: 0, exp_done: 6};
    jobs[6] = '{base: 10'h3F0, strd: 10'h007, cnt: 16'd20, mode: 2, exp_done: -1};
    jobs[7] = '{base: 10'h200, strd: 10'h001, cnt: 16'd1,  mode: 0, exp_done: 4};

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    cmp("rst_busy", longint'(busy), 0);
    cmp("rst_done", longint'(done), 0);
    cmp("rst_mem_en", longint'(bus.mem_en), 0);
    cmp("rst_mem_addr", longint'(bus.mem_addr), 0);
    cmp("rst_dout", longint'(bus.dout), 0);
    cmp("rst_dout_v", longint'(bus.dout_v), 0);
    step(1'b0, 1'b1, 1'b0);

    foreach (jobs[i]) run_job(jobs[i]);

    // Reset after two of five words: job aborts silently, then reruns cleanly.
    base_addr = 10'h020; stride = 10'h002; count = 16'd5;
    for (int i = 0; i < 5; i++) q.push_back(mdata(AW'(10'h020 + 2 * i)));
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 5; k++) step(1'b0, 1'b1, 1'b0);
    cmp("pre_rst_words_left", q.size(), 3);
    step(1'b0, 1'b0, 1'b1);
    q.delete();
    step(1'b0, 1'b1, 1'b0);
    cmp("abort_dout_v", longint'(bus.dout_v), 0);
    cmp("abort_busy", longint'(busy), 0);
    cmp("abort_done", longint'(done), 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0);
      cmp("abort_no_done", longint'(done), 0);
      cmp("abort_no_mem_en", longint'(bus.mem_en), 0);
    end
    run_job('{base: 10'h020, strd: 10'h002, cnt: 16'd5, mode: 0, exp_done: 8});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
